// File: rtl/scheduler_sched_info_table.sv
// scheduler_sched_info_table
//
// Purpose: per-accelerator-type scheduling info table. Each entry has a
// DATA_WIDTH payload and a valid bit. The table has one write/invalidate port,
// a clear_all pulse, and NUM_RD_PORTS registered read ports with 1-cycle
// latency. A registered count of valid entries drives the full/empty flags.
//
// Ports:
//   clk          sole clock, rising edge
//   rstn         asynchronous active-low reset
//   wr_en        write/invalidate request (one op per cycle)
//   wr_inv       with wr_en: invalidate the entry instead of writing it
//   wr_addr      target entry
//   wr_din       payload written on wr_en & ~wr_inv
//   clear_all    pulse that invalidates every entry; overrides a same-cycle write
//   rd_en        per-port read enable
//   rd_addr      per-port address, port i at [i*ACC_TYPE_BITS +: ACC_TYPE_BITS]
//   rd_dout      per-port registered payload, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_valid     per-port registered valid flag of the entry that was read
//   valid_count  number of valid entries
//   full / empty valid_count == MAX_ACC_TYPES / valid_count == 0
//
// Build option: define SCHED_INFO_TABLE_BYPASS_EN to forward a same-cycle
// write to a read of the same address. Without it, reads are read-first.
//
// An invalid entry reads back as rd_dout = 0 and rd_valid = 0. Because of
// this, the payload RAM can stay unreset and still never leak stale data.

module scheduler_sched_info_table #(
  parameter int MAX_ACC_TYPES = 16,
  parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
  parameter int DATA_WIDTH    = 50,
  parameter int NUM_RD_PORTS  = 2,
  parameter int CNT_BITS      = $clog2(MAX_ACC_TYPES + 1)
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  wr_en,
  input  logic                                  wr_inv,
  input  logic [ACC_TYPE_BITS-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]                 wr_din,
  input  logic                                  clear_all,
  input  logic [NUM_RD_PORTS-1:0]               rd_en,
  input  logic [NUM_RD_PORTS*ACC_TYPE_BITS-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rd_dout,
  output logic [NUM_RD_PORTS-1:0]               rd_valid,
  output logic [CNT_BITS-1:0]                   valid_count,
  output logic                                  full,
  output logic                                  empty
);

  localparam logic [ACC_TYPE_BITS:0] LP_ADDR_LIM = (ACC_TYPE_BITS+1)'(MAX_ACC_TYPES);
  localparam logic [CNT_BITS-1:0]    LP_CNT_MAX  = CNT_BITS'(MAX_ACC_TYPES);

  logic [DATA_WIDTH-1:0]    r_mem [MAX_ACC_TYPES];
  logic [MAX_ACC_TYPES-1:0] r_valid;
  logic [CNT_BITS-1:0]      r_count;

  logic w_wr_in_range;
  logic w_wr_ok;
  logic w_wr_tgt_valid;
  logic w_cnt_inc;
  logic w_cnt_dec;

  assign w_wr_in_range  = ({1'b0, wr_addr} < LP_ADDR_LIM);
  assign w_wr_ok        = wr_en & w_wr_in_range;
  assign w_wr_tgt_valid = w_wr_in_range ? r_valid[wr_addr] : 1'b0;

  // Only state transitions of the target valid bit move the count.
  assign w_cnt_inc = w_wr_ok & ~wr_inv & ~w_wr_tgt_valid;
  assign w_cnt_dec = w_wr_ok &  wr_inv &  w_wr_tgt_valid;

  // Payload RAM: no reset. rstn gating stops a write that lands on an edge
  // while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && w_wr_ok && !wr_inv && !clear_all) begin
      r_mem[wr_addr] <= wr_din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
    end else if (clear_all) begin
      r_valid <= '0;
    end else if (w_wr_ok) begin
      r_valid[wr_addr] <= ~wr_inv;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clear_all) begin
      r_count <= '0;
    end else if (w_cnt_inc && (r_count != LP_CNT_MAX)) begin
      r_count <= r_count + CNT_BITS'(1);
    end else if (w_cnt_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_BITS'(1);
    end
  end

  assign valid_count = r_count;
  assign full        = (r_count == LP_CNT_MAX);
  assign empty       = (r_count == '0);

  for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_rd
    logic [ACC_TYPE_BITS-1:0] w_addr;
    logic                     w_in_range;
    logic [DATA_WIDTH-1:0]    w_dout_nxt;
    logic                     w_valid_nxt;
    logic [DATA_WIDTH-1:0]    r_dout;
    logic                     r_vld;

    assign w_addr     = rd_addr[gp*ACC_TYPE_BITS +: ACC_TYPE_BITS];
    assign w_in_range = ({1'b0, w_addr} < LP_ADDR_LIM);

    always_comb begin
      w_dout_nxt  = '0;
      w_valid_nxt = 1'b0;
      if (w_in_range && r_valid[w_addr]) begin
        w_dout_nxt  = r_mem[w_addr];
        w_valid_nxt = 1'b1;
      end
`ifdef SCHED_INFO_TABLE_BYPASS_EN
      // A same-cycle write wins over stored state, but clear_all
      // discards that write, so the read then sees pre-clear contents.
      if (w_in_range && w_wr_ok && !clear_all && (wr_addr == w_addr)) begin
        w_dout_nxt  = wr_inv ? '0 : wr_din;
        w_valid_nxt = ~wr_inv;
      end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_dout <= '0;
        r_vld  <= 1'b0;
      end else if (rd_en[gp]) begin
        r_dout <= w_dout_nxt;
        r_vld  <= w_valid_nxt;
      end
    end

    assign rd_dout[gp*DATA_WIDTH +: DATA_WIDTH] = r_dout;
    assign rd_valid[gp]                         = r_vld;
  end

endmodule

// File: tb/tb_scheduler_sched_info_table.sv
module tb_scheduler_sched_info_table;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 50;
  localparam int NP = 2;
  localparam int CW = 5;

  logic               clk = 1'b0;
  logic               rstn;
  logic               wr_en, wr_inv, clear_all;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_din;
  logic [NP-1:0]      rd_en;
  logic [NP*AW-1:0]   rd_addr;
  logic [NP*DW-1:0]   rd_dout;
  logic [NP-1:0]      rd_valid;
  logic [CW-1:0]      valid_count;
  logic               full, empty;

  always #5 clk = ~clk;

  scheduler_sched_info_table dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_inv(wr_inv), .wr_addr(wr_addr), .wr_din(wr_din),
    .clear_all(clear_all),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dout(rd_dout), .rd_valid(rd_valid),
    .valid_count(valid_count), .full(full), .empty(empty)
  );

  // Reference model: the table contents and the expected registered outputs.
  logic [DW-1:0] m_mem   [N];
  bit            m_valid [N];
  logic [DW-1:0] e_dout  [NP];
  bit            e_vld   [NP];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  function automatic logic [DW-1:0] dout_of(input int p);
    return rd_dout[p*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    for (int p = 0; p < NP; p++) begin
      e_dout[p] = '0;
      e_vld[p]  = 0;
    end
  endtask

  // Predict from the inputs currently applied, clock once, then compare at
  // the following falling edge.
  task automatic cycle();
    int a;
    for (int p = 0; p < NP; p++) begin
      if (rd_en[p]) begin
        a = int'(rd_addr[p*AW +: AW]);
        e_vld[p]  = m_valid[a];
        e_dout[p] = m_valid[a] ? m_mem[a] : '0;
`ifdef SCHED_INFO_TABLE_BYPASS_EN
        if (wr_en && !clear_all && int'(wr_addr) == a) begin
          e_vld[p]  = !wr_inv;
          e_dout[p] = wr_inv ? '0 : wr_din;
        end
`endif
      end
    end
    if (clear_all) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else if (wr_en) begin
      if (wr_inv) m_valid[wr_addr] = 0;
      else begin
        m_valid[wr_addr] = 1;
        m_mem[wr_addr]   = wr_din;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("rd_valid[%0d]", p), 64'(rd_valid[p]), 64'(e_vld[p]));
      chk($sformatf("rd_dout[%0d]", p), 64'(dout_of(p)), 64'(e_dout[p]));
    end
    chk("valid_count", 64'(valid_count), 64'(model_count()));
    chk("full", 64'(full), 64'(model_count() == N));
    chk("empty", 64'(empty), 64'(model_count() == 0));
  endtask

  task automatic op(input bit we, input bit inv, input logic [AW-1:0] wa,
                    input logic [DW-1:0] d, input bit clr, input logic [NP-1:0] re,
                    input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en = we; wr_inv = inv; wr_addr = wa; wr_din = d; clear_all = clr;
    rd_en = re; rd_addr = {ra1, ra0};
    cycle();
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_inv = 0; wr_addr = '0; wr_din = '0; clear_all = 0;
    rd_en = '0; rd_addr = '0;
  endtask

  initial begin
    logic [63:0] r64;
    idle_inputs();
    rstn = 1'b0;
    model_reset();
    #12;
    chk("reset rd_valid", 64'(rd_valid), 64'(0));
    chk("reset rd_dout", 64'(rd_dout[63:0]), 64'(0));
    chk("reset valid_count", 64'(valid_count), 64'(0));
    chk("reset empty", 64'(empty), 64'(1));
    chk("reset full", 64'(full), 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    // Read an unwritten address straight after reset.
    op(0, 0, 0, 0, 0, 2'b01, 4'd3, 4'd0);
    chk("r037 dout0", 64'(dout_of(0)), 64'(0));
    chk("r037 valid0", 64'(rd_valid[0]), 64'(0));
    chk("r037 count", 64'(valid_count), 64'(0));
    chk("r037 empty", 64'(empty), 64'(1));

    // Write, then read the same entry on both ports.
    op(1, 0, 4'd5, 50'h2_0000_0000_00AB, 0, 2'b00, 0, 0);
    op(0, 0, 0, 0, 0, 2'b11, 4'd5, 4'd5);
    chk("r038 dout0", 64'(dout_of(0)), 64'h2_0000_0000_00AB);
    chk("r038 dout1", 64'(dout_of(1)), 64'h2_0000_0000_00AB);
    chk("r038 valid", 64'(rd_valid), 64'(2'b11));
    chk("r038 count", 64'(valid_count), 64'(1));

    // Fill the table, rewrite one entry, then invalidate one.
    for (int i = 0; i < N; i++) op(1, 0, AW'(i), DW'(100 + i), 0, 2'b00, 0, 0);
    chk("r039 count16", 64'(valid_count), 64'(16));
    chk("r039 full", 64'(full), 64'(1));
    op(1, 0, 4'd0, 50'h3FF, 0, 2'b00, 0, 0);
    chk("r039 rewrite count", 64'(valid_count), 64'(16));
    op(1, 1, 4'd7, 0, 0, 2'b00, 0, 0);
    chk("r039 inv count", 64'(valid_count), 64'(15));
    chk("r039 inv full", 64'(full), 64'(0));

    // Same-cycle write and read of the same address.
    op(1, 0, 4'd2, 50'h09, 0, 2'b00, 0, 0);
    op(1, 0, 4'd2, 50'h15, 0, 2'b01, 4'd2, 0);
`ifdef SCHED_INFO_TABLE_BYPASS_EN
    chk("r040 bypass", 64'(dout_of(0)), 64'h15);
`else
    chk("r040 readfirst", 64'(dout_of(0)), 64'h09);
`endif
    chk("r040 valid", 64'(rd_valid[0]), 64'(1));

    // clear_all beats a concurrent write.
    op(0, 0, 0, 0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 10; i++) op(1, 0, AW'(i), DW'(200 + i), 0, 2'b00, 0, 0);
    chk("r041 count10", 64'(valid_count), 64'(10));
    op(1, 0, 4'd4, 50'hABC, 1, 2'b01, 4'd4, 0);
    chk("r041 count0", 64'(valid_count), 64'(0));
    chk("r041 preclear read", 64'(dout_of(0)), 64'(204));
    op(0, 0, 0, 0, 0, 2'b01, 4'd4, 0);
    chk("r041 valid", 64'(rd_valid[0]), 64'(0));

    // Asynchronous reset in the middle of a write burst.
    op(0, 0, 0, 0, 1, 2'b00, 0, 0);
    for (int i = 0; i < 6; i++) op(1, 0, AW'(i), DW'(300 + i), 0, 2'b11, 4'd0, 4'd1);
    chk("r042 count6", 64'(valid_count), 64'(6));
    chk("r042 pre valid", 64'(rd_valid), 64'(2'b11));
    wr_en = 1; wr_inv = 0; wr_addr = 4'd8; wr_din = 50'h777; rd_en = 2'b11;
    rd_addr = {4'd2, 4'd8};
    #2 rstn = 1'b0;
    #1;
    chk("r042 async rd_valid", 64'(rd_valid), 64'(0));
    chk("r042 async rd_dout", 64'(rd_dout[63:0]), 64'(0));
    chk("r042 async count", 64'(valid_count), 64'(0));
    chk("r042 async empty", 64'(empty), 64'(1));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rstn = 1'b1;
    #1;
    chk("r042 release empty", 64'(empty), 64'(1));
    chk("r042 release count", 64'(valid_count), 64'(0));
    @(negedge clk);
    op(0, 0, 0, 0, 0, 2'b01, 4'd8, 0);
    chk("r042 dropped write", 64'(rd_valid[0]), 64'(0));

    // Randomized traffic against the model.
    for (int k = 0; k < 800; k++) begin
      r64 = {$urandom, $urandom};
      op(bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 3) == 0),
         AW'($urandom_range(0, N - 1)), r64[DW-1:0],
         bit'($urandom_range(0, 39) == 0), NP'($urandom_range(0, 3)),
         AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
